// File: rtl/mem_arbiter.sv
// mem_arbiter
// ---------------------------------------------------------------------------
// Two-port arbiter that places either the processor data port or the DMA
// wrapper's RAM master onto one synchronous RAM. It serves one request at a
// time and walks it through four states:
//    IDLE -> ACCESS -> WAIT (RAM_LATENCY cycles) -> DONE -> IDLE
// The grantee receives a one-cycle done pulse. On a read, its rdata register
// carries the captured RAM word.
//
// Configuration macro MEM_ARB_RR_EN:
//    undefined : fixed priority, the CPU wins a tie.
//    defined   : round-robin on ties, using a 1-bit last-grant register.
//                That register resets to "DMA last".
//
// Ports
//    clk_i, rst_i                  clock, synchronous active-high reset
//    cpu_valid/read/write          processor request qualifiers
//    cpu_address/wdata/wstrb       processor byte address, write data, strobes
//    cpu_rdata/ready/done          processor responses
//    dma_*                         same set for the DMA RAM master
//    ram_cs, ram_we                RAM chip select and byte write enables
//    ram_addr, ram_wdata           RAM word address and write data
//    ram_rdata                     RAM read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_BITS  = 32,
   parameter int RAM_ADDR_BITS = 12,
   parameter int RAM_LATENCY   = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cpu_valid,
   input  logic                       cpu_read,
   input  logic                       cpu_write,
   input  logic [ADDRESS_BITS-1:0]    cpu_address,
   input  logic [DATA_WIDTH-1:0]      cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0]    cpu_wstrb,
   output logic [DATA_WIDTH-1:0]      cpu_rdata,
   output logic                       cpu_ready,
   output logic                       cpu_done,
   input  logic                       dma_valid,
   input  logic                       dma_read,
   input  logic                       dma_write,
   input  logic [ADDRESS_BITS-1:0]    dma_address,
   input  logic [DATA_WIDTH-1:0]      dma_wdata,
   input  logic [DATA_WIDTH/8-1:0]    dma_wstrb,
   output logic [DATA_WIDTH-1:0]      dma_rdata,
   output logic                       dma_ready,
   output logic                       dma_done,
   output logic                       ram_cs,
   output logic [DATA_WIDTH/8-1:0]    ram_we,
   output logic [RAM_ADDR_BITS-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]      ram_wdata,
   input  logic [DATA_WIDTH-1:0]      ram_rdata
);

   localparam int          STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [3:0]  LAT_LOAD   = 4'(RAM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_e;

   state_e                    state_q, state_d;
   logic [3:0]                lat_cnt_q, lat_cnt_d;
   logic                      grant_cpu_s, grant_dma_s, grant_any_s;
   logic                      ready_s, wait_last_s;
   logic                      port_dma_q;     // grantee of the transaction in flight
   logic                      is_write_q;
   logic                      sel_write_s;
   logic [ADDRESS_BITS-1:0]   sel_addr_s;
   logic [DATA_WIDTH-1:0]     sel_wdata_s;
   logic [STRB_WIDTH-1:0]     sel_wstrb_s;
   logic                      ram_cs_q;
   logic [STRB_WIDTH-1:0]     ram_we_q;
   logic [RAM_ADDR_BITS-1:0]  ram_addr_q;
   logic [DATA_WIDTH-1:0]     ram_wdata_q;
   logic [DATA_WIDTH-1:0]     cpu_rdata_q, dma_rdata_q;
   logic                      cpu_done_q, dma_done_q;

   // read strobes carry no information (write wins, neither means read) and
   // the address bits outside the word index are ignored, so addresses alias
   logic                      unused_s;
   assign unused_s = ^{cpu_read, dma_read, cpu_address, dma_address};

`ifdef MEM_ARB_RR_EN
   logic                      last_dma_q;

   // Last-grant memory for round-robin tie breaking
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_dma_q <= 1'b1;
      end else if (grant_any_s) begin
         last_dma_q <= grant_dma_s;
      end
   end
`endif

   // Arbitration: decide the grantee combinationally on the IDLE cycle
   always_comb begin
      grant_cpu_s = 1'b0;
      grant_dma_s = 1'b0;
      if (state_q == IDLE) begin
`ifdef MEM_ARB_RR_EN
         if (cpu_valid && dma_valid) begin
            grant_cpu_s = last_dma_q;
            grant_dma_s = ~last_dma_q;
         end else begin
            grant_cpu_s = cpu_valid;
            grant_dma_s = dma_valid;
         end
`else
         grant_cpu_s = cpu_valid;
         grant_dma_s = dma_valid & ~cpu_valid;
`endif
      end else begin
         grant_cpu_s = 1'b0;
         grant_dma_s = 1'b0;
      end
   end

   assign grant_any_s = grant_cpu_s | grant_dma_s;

   // Request mux feeding the grant-time latches
   always_comb begin
      sel_write_s = cpu_write;
      sel_addr_s  = cpu_address;
      sel_wdata_s = cpu_wdata;
      sel_wstrb_s = cpu_wstrb;
      if (grant_dma_s) begin
         sel_write_s = dma_write;
         sel_addr_s  = dma_address;
         sel_wdata_s = dma_wdata;
         sel_wstrb_s = dma_wstrb;
      end else begin
         sel_write_s = cpu_write;
         sel_addr_s  = cpu_address;
         sel_wdata_s = cpu_wdata;
         sel_wstrb_s = cpu_wstrb;
      end
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         lat_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

   // FSM next state; WAIT spends exactly RAM_LATENCY cycles
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      case (state_q)
         IDLE: begin
            if (grant_any_s) begin
               state_d = ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d   = WAIT;
            lat_cnt_d = LAT_LOAD;
         end
         WAIT: begin
            if (lat_cnt_q == 4'd0) begin
               state_d = DONE;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            lat_cnt_d = 4'd0;
         end
      endcase
   end

   // FSM output decode
   always_comb begin
      ready_s     = (state_q == IDLE);
      wait_last_s = (state_q == WAIT) && (lat_cnt_q == 4'd0);
   end

   // Datapath: grant latches, RAM strobes, read capture and done pulses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         port_dma_q  <= 1'b0;
         is_write_q  <= 1'b0;
         ram_cs_q    <= 1'b0;
         ram_we_q    <= {STRB_WIDTH{1'b0}};
         ram_addr_q  <= {RAM_ADDR_BITS{1'b0}};
         ram_wdata_q <= {DATA_WIDTH{1'b0}};
         cpu_rdata_q <= {DATA_WIDTH{1'b0}};
         dma_rdata_q <= {DATA_WIDTH{1'b0}};
         cpu_done_q  <= 1'b0;
         dma_done_q  <= 1'b0;
      end else begin
         ram_cs_q   <= grant_any_s;
         cpu_done_q <= wait_last_s & ~port_dma_q;
         dma_done_q <= wait_last_s & port_dma_q;
         if (grant_any_s) begin
            port_dma_q  <= grant_dma_s;
            is_write_q  <= sel_write_s;
            ram_addr_q  <= sel_addr_s[RAM_ADDR_BITS+1:2];
            ram_wdata_q <= sel_wdata_s;
            ram_we_q    <= sel_write_s ? sel_wstrb_s : {STRB_WIDTH{1'b0}};
         end
         // last WAIT cycle is the one where ram_rdata is valid
         if (wait_last_s && !is_write_q) begin
            if (port_dma_q) begin
               dma_rdata_q <= ram_rdata;
            end else begin
               cpu_rdata_q <= ram_rdata;
            end
         end
      end
   end

   assign cpu_ready = ready_s;
   assign dma_ready = ready_s;
   assign cpu_done  = cpu_done_q;
   assign dma_done  = dma_done_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign ram_cs    = ram_cs_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int RAW     = 12;
   localparam int LAT     = 1;
   localparam int SW      = DW / 8;
   localparam int TIMEOUT = 4 * (LAT + 3) + 8;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            cpu_valid, cpu_read, cpu_write;
   logic [AW-1:0]   cpu_address;
   logic [DW-1:0]   cpu_wdata;
   logic [SW-1:0]   cpu_wstrb;
   logic [DW-1:0]   cpu_rdata;
   logic            cpu_ready, cpu_done;
   logic            dma_valid, dma_read, dma_write;
   logic [AW-1:0]   dma_address;
   logic [DW-1:0]   dma_wdata;
   logic [SW-1:0]   dma_wstrb;
   logic [DW-1:0]   dma_rdata;
   logic            dma_ready, dma_done;
   logic            ram_cs;
   logic [SW-1:0]   ram_we;
   logic [RAW-1:0]  ram_addr;
   logic [DW-1:0]   ram_wdata;
   logic [DW-1:0]   ram_rdata;

   mem_arbiter #(
      .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .RAM_ADDR_BITS(RAW), .RAM_LATENCY(LAT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_valid(cpu_valid), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
      .dma_valid(dma_valid), .dma_read(dma_read), .dma_write(dma_write),
      .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
      .dma_rdata(dma_rdata), .dma_ready(dma_ready), .dma_done(dma_done),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk_i = ~clk_i;

   longint cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // ---------------- synchronous RAM with LAT-cycle read latency ----------
   logic          mem_clear;
   logic [DW-1:0] ram_mem [0:(1<<RAW)-1];
   logic [DW-1:0] rd_pipe [0:LAT-1];

   always @(posedge clk_i) begin
      if (mem_clear) begin
         for (int i = 0; i < (1 << RAW); i++) ram_mem[i] <= '0;
         for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
      end else begin
         if (ram_cs) begin
            rd_pipe[0] <= ram_mem[ram_addr];
            for (int b = 0; b < SW; b++)
               if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         end
         for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end
   assign ram_rdata = rd_pipe[LAT-1];

   // ---------------- checking infrastructure ------------------------------
   int errors = 0;
   int checks = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   typedef struct {
      logic          wr;
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
   } req_t;

   typedef struct {
      int            port;      // 0 = CPU, 1 = DMA
      logic [DW-1:0] cpu_rd;
      logic [DW-1:0] dma_rd;
      longint        cyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [7:0]    ref_bytes [int];     // byte-granular reference memory
   logic [DW-1:0] model_rd [2];        // what each port's rdata should hold
   int            last_port = 1;       // last granted port, reset means DMA

   function automatic logic [RAW-1:0] word_of(input logic [AW-1:0] a);
      return RAW'((a / 32'd4) % (32'd1 << RAW));
   endfunction

   function automatic req_t mk_req(input logic wr, input logic rd, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d, input logic [SW-1:0] s);
      req_t r;
      r.wr = wr; r.rd = rd; r.addr = a; r.wdata = d; r.strb = s;
      return r;
   endfunction

   function automatic req_t rand_req();
      return mk_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 7)) << 2),
                    $urandom, SW'($urandom_range(0, 15)));
   endfunction

   function automatic int tie_winner();
`ifdef MEM_ARB_RR_EN
      return (last_port == 1) ? 0 : 1;
`else
      return 0;
`endif
   endfunction

   // Apply one transaction to the reference model and queue its response.
   function automatic void model_txn(input int port, input req_t r, input longint done_cyc);
      int   base;
      exp_t e;
      logic [DW-1:0] v;
      base = int'(word_of(r.addr)) * SW;
      if (r.wr) begin
         for (int b = 0; b < SW; b++)
            if (r.strb[b]) ref_bytes[base + b] = r.wdata[b*8 +: 8];
      end else begin
         for (int b = 0; b < SW; b++)
            v[b*8 +: 8] = ref_bytes.exists(base + b) ? ref_bytes[base + b] : 8'h00;
         model_rd[port] = v;
      end
      e.port   = port;
      e.cpu_rd = model_rd[0];
      e.dma_rd = model_rd[1];
      e.cyc    = done_cyc;
      exp_q.push_back(e);
   endfunction

   // ---------------- monitor ----------------------------------------------
   exp_t mon_e;
   always @(negedge clk_i) begin
      if (cpu_done || dma_done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got cpu_done=%0b dma_done=%0b want none (cycle %0d)",
                     cpu_done, dma_done, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("done_port", {62'd0, cpu_done, dma_done}, (mon_e.port == 0) ? 64'd2 : 64'd1);
            chk("done_cycle", cyc, mon_e.cyc);
            chk("cpu_rdata", cpu_rdata, mon_e.cpu_rd);
            chk("dma_rdata", dma_rdata, mon_e.dma_rd);
         end
      end
   end

   // ---------------- requester drivers ------------------------------------
   task automatic drive_cpu(input req_t r);
      bit seen = 1'b0;
      cpu_valid = 1'b1; cpu_read = r.rd; cpu_write = r.wr;
      cpu_address = r.addr; cpu_wdata = r.wdata; cpu_wstrb = r.strb;
      for (int i = 0; i < TIMEOUT && !seen; i++) begin
         @(negedge clk_i);
         if (cpu_done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL cpu_done_timeout got=0 want=1 (cycle %0d)", cyc);
      end
      @(posedge clk_i); #1;
      cpu_valid = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
   endtask

   task automatic drive_dma(input req_t r);
      bit seen = 1'b0;
      dma_valid = 1'b1; dma_read = r.rd; dma_write = r.wr;
      dma_address = r.addr; dma_wdata = r.wdata; dma_wstrb = r.strb;
      for (int i = 0; i < TIMEOUT && !seen; i++) begin
         @(negedge clk_i);
         if (dma_done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL dma_done_timeout got=0 want=1 (cycle %0d)", cyc);
      end
      @(posedge clk_i); #1;
      dma_valid = 1'b0; dma_read = 1'b0; dma_write = 1'b0;
   endtask

   // Issue from an IDLE cycle; predicts grant order and completion cycles.
   task automatic issue(input bit use_cpu, input bit use_dma, input req_t rc, input req_t rd);
      longint n;
      int     first;
      req_t   fr;
      n = cyc;
      if (use_cpu && use_dma) first = tie_winner();
      else if (use_cpu)       first = 0;
      else                    first = 1;
      fr = (first == 0) ? rc : rd;
      model_txn(first, fr, n + 2 + LAT);
      last_port = first;
      if (use_cpu && use_dma) begin
         model_txn(1 - first, (first == 0) ? rd : rc, n + 2 + LAT + (LAT + 3));
         last_port = 1 - first;
      end
      fork
         begin if (use_cpu) drive_cpu(rc); end
         begin if (use_dma) drive_dma(rd); end
         begin
            @(posedge clk_i); #1;
            chk("access_cs", ram_cs, 1);
            chk("access_addr", ram_addr, word_of(fr.addr));
            chk("access_we", ram_we, fr.wr ? fr.strb : '0);
            chk("access_wdata", ram_wdata, fr.wdata);
            chk("busy_cpu_ready", cpu_ready, 0);
            chk("busy_dma_ready", dma_ready, 0);
            @(posedge clk_i); #1;
            chk("cs_one_cycle", ram_cs, 0);
         end
      join
      chk("idle_cpu_ready", cpu_ready, 1);
      chk("idle_dma_ready", dma_ready, 1);
   endtask

   task automatic check_reset_values();
      chk("rst_ram_cs", ram_cs, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
      chk("rst_cpu_done", cpu_done, 0);
      chk("rst_dma_done", dma_done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ---------------------------------------------
   initial begin
      cpu_valid = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
      cpu_address = '0; cpu_wdata = '0; cpu_wstrb = '0;
      dma_valid = 1'b0; dma_read = 1'b0; dma_write = 1'b0;
      dma_address = '0; dma_wdata = '0; dma_wstrb = '0;
      model_rd[0] = '0; model_rd[1] = '0;
      mem_clear = 1'b1;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i); #1;
      check_reset_values();
      rst_i = 1'b0; mem_clear = 1'b0;
      @(posedge clk_i); #1;
      chk("rel_cpu_ready", cpu_ready, 1);
      chk("rel_dma_ready", dma_ready, 1);

      // directed: DMA full write, CPU read back, CPU partial write, DMA read back
      issue(0, 1, mk_req(0, 0, '0, '0, '0), mk_req(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF));
      issue(1, 0, mk_req(0, 1, 32'h0000_0010, '0, '0), mk_req(0, 0, '0, '0, '0));
      issue(1, 0, mk_req(1, 0, 32'h0000_0010, 32'h0000_1234, 4'h3), mk_req(0, 0, '0, '0, '0));
      issue(0, 1, mk_req(0, 0, '0, '0, '0), mk_req(0, 1, 32'h0000_0010, '0, '0));

      // reset during the ACCESS cycle of a DMA read
      dma_valid = 1'b1; dma_read = 1'b1; dma_write = 1'b0; dma_address = 32'h0000_0010;
      @(posedge clk_i); #1;
      chk("abort_access_cs", ram_cs, 1);
      rst_i = 1'b1; dma_valid = 1'b0; dma_read = 1'b0;
      repeat (2) @(posedge clk_i); #1;
      check_reset_values();
      chk("abort_ready", dma_ready, 1);
      rst_i = 1'b0;
      model_rd[0] = '0; model_rd[1] = '0;
      last_port = 1;
      repeat (LAT + 4) @(posedge clk_i); #1;

      // two back-to-back ties, then a normal DMA read
      issue(1, 1, mk_req(0, 1, 32'h0000_0010, '0, '0), mk_req(1, 0, 32'h0000_0020, 32'hA5A5_0F0F, 4'hF));
      issue(1, 1, mk_req(0, 0, 32'hFFFF_C020, '0, '0), mk_req(1, 1, 32'h0000_0013, 32'h7777_8888, 4'hC));
      issue(0, 1, mk_req(0, 0, '0, '0, '0), mk_req(0, 1, 32'h0000_0010, '0, '0));

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         int kind;
         kind = $urandom_range(0, 2);
         issue(kind != 1, kind != 0, rand_req(), rand_req());
         repeat ($urandom_range(0, 2)) @(posedge clk_i);
         #1;
      end

      repeat (LAT + 4) @(posedge clk_i); #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port RAM arbiter sitting directly downstream of the DMA wrapper's RAM master port (`tdma_ram_*`) and the processor's data port. It grants one requester at a time onto a single synchronous RAM. It drives the RAM strobes and counts the RAM read latency. It returns a one-cycle `done` pulse with read data to the granted requester. Its request protocol is `ready`, then `valid` with `read`/`write` held until `done`, which is exactly what the DMA wrapper's RAM master expects.

## Interface
- `DATA_WIDTH`, 32: data bus width; strobe width is DATA_WIDTH/8.
- `ADDRESS_BITS`, 32: requester byte-address width.
- `RAM_ADDR_BITS`, 12: RAM word-address width.
- `RAM_LATENCY`, 1: cycles from `ram_cs` to valid `ram_rdata`; legal range 1..15.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `cpu_valid`, `cpu_read`, `cpu_write` in 1 each: processor request.
- `cpu_address` in ADDRESS_BITS: processor byte address.
- `cpu_wdata` in DATA_WIDTH, `cpu_wstrb` in DATA_WIDTH/8: processor write data and byte strobes.
- `cpu_rdata` out DATA_WIDTH, `cpu_ready` out 1, `cpu_done` out 1: processor responses.
- `dma_valid`, `dma_read`, `dma_write`, `dma_address`, `dma_wdata`, `dma_wstrb`: DMA request, same widths as the processor port (DMA wrapper `tdma_ram_*`).
- `dma_rdata`, `dma_ready`, `dma_done` out: DMA responses (wrapper `tdma_ram_data_in`, `tdma_ram_ready`, `ram_done`).
- `ram_cs` out 1, `ram_we` out DATA_WIDTH/8: RAM chip select and byte write enables.
- `ram_addr` out RAM_ADDR_BITS, `ram_wdata` out DATA_WIDTH: RAM address and write data.
- `ram_rdata` in DATA_WIDTH: RAM read data.

## Operation
- State machine states:
  - IDLE: sample requests and grant.
  - ACCESS: drive `ram_cs` for 1 cycle.
  - WAIT: latency counter.
  - DONE: pulse `done` to the grantee, return to IDLE.
- Ready: `cpu_ready` and `dma_ready` equal (state==IDLE), combinational.
- Grant: in IDLE, a port with `valid`=1 is granted. The grant latches the port id, `ram_addr` = address[RAM_ADDR_BITS+1:2], `ram_wdata`, and `ram_we` (= wstrb if `write`, else 0). Next state is ACCESS.
- Out-of-range address: upper byte-address bits and bits [1:0] are ignored, so accesses alias.
- Read/write precedence: `write`=1 takes precedence over `read`. `valid` with neither asserted completes as a read.
- Write with wstrb=0: `ram_we`=0, but the transaction still completes with `done`.
- Losing requester: holds `valid` and is granted in the first IDLE cycle after the current transaction. There is no timeout.
- Read data: RAM data is captured only for reads into the grantee's `rdata` register. The register holds until that port's next read completes. Writes leave `rdata` unchanged.
- Done: `<port>_done` is a 1-cycle pulse, only to the grantee. The requester must drop `valid` by the cycle after `done`. A still-high `valid` in the following IDLE is treated as a new request.
- Reset: values on `rst_i`=1 (and mid-operation):
  - State IDLE.
  - `ram_cs`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `cpu_rdata`=`dma_rdata`=0, `cpu_done`=`dma_done`=0.
  - `cpu_ready`=`dma_ready`=1 once reset is released.
  - Any in-flight transaction is dropped and no `done` is issued.

## Timing
- Cycle N: IDLE with `valid` sampled.
- Cycle N+1: ACCESS; `ram_cs`=1 for exactly one cycle, with `ram_we`/`ram_addr`/`ram_wdata` registered.
- Cycle N+1+RAM_LATENCY: `ram_rdata` valid and captured at the end of the cycle; WAIT counts RAM_LATENCY cycles.
- Cycle N+2+RAM_LATENCY: DONE; `done`=1 and `rdata` valid.
- Cycle N+3+RAM_LATENCY: IDLE; `ready`=1 and a new grant is possible this cycle.
- Ready windows: `ready`=0 from N+1 through N+2+RAM_LATENCY. Writes use the same latency as reads.
- Throughput: one transaction per RAM_LATENCY+3 cycles.
- Grant decision: combinational on the IDLE cycle; no added bubble.

## Configuration
- Macro `MEM_ARB_RR_EN` selects the arbitration policy.
- Undefined: fixed priority. On simultaneous `valid`, the CPU is granted; the DMA can starve under continuous CPU traffic.
- Defined: round-robin. A 1-bit last-grant register is updated on each grant. On simultaneous `valid`, the port not granted last wins. Reset value is "DMA last", so the first tie goes to the CPU. A single requester is always granted immediately.

## Test plan
- Reset: assert `rst_i` 2 cycles. Required: all outputs at the listed reset values; `cpu_ready`=`dma_ready`=1 after release.
- DMA write, RAM_LATENCY=1: `dma_address`=0x0000_0010, `dma_wdata`=0xDEADBEEF, `dma_wstrb`=0xF at cycle N. Required at N+1: `ram_cs`=1, `ram_addr`=4, `ram_we`=0xF, `ram_wdata`=0xDEADBEEF. Required at N+3: `dma_done`=1. Required at N+4: `dma_ready`=1.
- CPU read of the same word, RAM model returning 0xDEADBEEF. Required at N+3: `cpu_done`=1, `cpu_rdata`=0xDEADBEEF. `dma_rdata` must be unchanged.
- Partial write: `wstrb`=0x3, data 0x0000_1234 to word 4. Required: `ram_we`=0x3; readback 0xDEAD1234.
- Simultaneous CPU and DMA `valid` at N, RAM_LATENCY=1:
  - Without the macro: `cpu_done` at N+3, `dma_done` at N+7.
  - With `MEM_ARB_RR_EN`, two back-to-back ties: grants go CPU, DMA, CPU, DMA.
- Reset at the ACCESS cycle of a DMA read. Required: no `dma_done`, state IDLE, and a new request afterwards completes normally.
